// File: rtl/mult_sched_pkg.sv
// Shared types and default sizing for the mult_sched multiplier scheduler.
// The optional watchdog is enabled with the MULT_SCHED_TIMEOUT_EN macro.
package mult_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } sched_state_t;

   localparam int DEF_WIDTH   = 32;
   localparam int DEF_NREQ    = 4;
   localparam int DEF_TIMEOUT = 256;

endpackage

// File: rtl/mult_sched_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request strictly after
// last_grant, wrapping NREQ-1 -> 0, so last_grant itself has lowest priority.
module rr_arbiter
   import mult_sched_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] last_grant,
   output logic [IDXW-1:0] grant_idx,
   output logic            grant_valid
);

   logic [IDXW-1:0] cand;

   // Scan from farthest to nearest so the nearest requester overwrites the rest.
   always_comb begin
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = IDXW'((int'(last_grant) + k) % NREQ);
         if (req[cand]) begin
            grant_idx   = cand;
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one multiplier among NREQ requesters.
// Define MULT_SCHED_TIMEOUT_EN to add a WAIT-state watchdog that reports rsp_err.
module mult_sched
   import mult_sched_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NREQ    = DEF_NREQ,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       req_ready,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [2*WIDTH-1:0]    rsp_dout,
   output logic                  rsp_err,
   output logic                  busy,
   output logic                  start,
   output logic [WIDTH-1:0]      A,
   output logic [WIDTH-1:0]      B,
   input  logic                  done,
   input  logic [2*WIDTH-1:0]    dout
);

   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

   sched_state_t       state_q, state_d;
   logic [IDXW-1:0]    grant_q, grant_d;
   logic [IDXW-1:0]    last_grant_q, last_grant_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic               done_prev_q;
   logic               done_edge;
   logic [IDXW-1:0]    arb_idx;
   logic               arb_valid;

`ifdef MULT_SCHED_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req         (req_valid),
      .last_grant  (last_grant_q),
      .grant_idx   (arb_idx),
      .grant_valid (arb_valid)
   );

   // A done level left high by a previous operation must not count as completion.
   assign done_edge = done & ~done_prev_q;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      a_d          = a_q;
      b_d          = b_q;
      prod_d       = prod_q;
      req_ready    = '0;
      rsp_valid    = '0;
      rsp_dout     = '0;
      rsp_err      = 1'b0;
      start        = 1'b0;
      A            = '0;
      B            = '0;
      busy         = (state_q != IDLE);
`ifdef MULT_SCHED_TIMEOUT_EN
      err_d        = err_q;
      cnt_d        = '0;
`endif
      case (state_q)
         IDLE: begin
            if (arb_valid) begin
               req_ready[arb_idx] = 1'b1;
               grant_d            = arb_idx;
               a_d                = req_a[int'(arb_idx)*WIDTH +: WIDTH];
               b_d                = req_b[int'(arb_idx)*WIDTH +: WIDTH];
               state_d            = START;
`ifdef MULT_SCHED_TIMEOUT_EN
               err_d              = 1'b0;
`endif
            end
         end
         START: begin
            start   = 1'b1;
            A       = a_q;
            B       = b_q;
            state_d = WAIT;
         end
         WAIT: begin
            A = a_q;
            B = b_q;
            if (done_edge) begin
               prod_d  = dout;
               state_d = RESP;
            end
`ifdef MULT_SCHED_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               prod_d  = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         RESP: begin
            rsp_valid[grant_q] = 1'b1;
            rsp_dout           = prod_q;
`ifdef MULT_SCHED_TIMEOUT_EN
            rsp_err            = err_q;
`endif
            last_grant_d       = grant_q;
            state_d            = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Keep every output quiet while reset is high so an abandoned op emits nothing.
      if (reset) begin
         req_ready = '0;
         rsp_valid = '0;
         rsp_dout  = '0;
         rsp_err   = 1'b0;
         start     = 1'b0;
         A         = '0;
         B         = '0;
         busy      = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= IDXW'(NREQ - 1);
         a_q          <= '0;
         b_q          <= '0;
         prod_q       <= '0;
         done_prev_q  <= 1'b0;
`ifdef MULT_SCHED_TIMEOUT_EN
         err_q        <= 1'b0;
         cnt_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         a_q          <= a_d;
         b_q          <= b_d;
         prod_q       <= prod_d;
         done_prev_q  <= done;
`ifdef MULT_SCHED_TIMEOUT_EN
         err_q        <= err_d;
         cnt_q        <= cnt_d;
`endif
      end
   end

endmodule
